// File: rtl/ps2_kbd_rx_if.sv
// ============================================================================
// ps2_kbd_rx_if : PS/2 pins, MMIO pop strobe and keyboard status bundle
// Revision      : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface ps2_kbd_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       kbd_read_enable;
  logic       kbd_ready;
  logic [7:0] kbd_data;
  logic       kbd_overflow;
  logic       frame_err;

  // Master is the keyboard/MMIO side, slave is the receiver.
  modport master (
    output ps2_clk, ps2_data, kbd_read_enable,
    input  kbd_ready, kbd_data, kbd_overflow, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data, kbd_read_enable,
    output kbd_ready, kbd_data, kbd_overflow, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
// ============================================================================
// ps2_kbd_rx : PS/2 keyboard frame receiver with scancode FIFO for MMIO reads
// Revision   : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ps2_kbd_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rst,
  ps2_kbd_rx_if.slave    bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] c_TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   c_PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [3:0]    c_STOP_BIT = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  // Input synchronisers; idle-high so reset never fakes a falling edge.
  logic ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
  logic ps2d_s1_q, ps2d_s2_q;
  logic w_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ps2c_s1_q   <= 1'b1;
      ps2c_s2_q   <= 1'b1;
      ps2c_prev_q <= 1'b1;
      ps2d_s1_q   <= 1'b1;
      ps2d_s2_q   <= 1'b1;
    end else begin
      ps2c_s1_q   <= bus.ps2_clk;
      ps2c_s2_q   <= ps2c_s1_q;
      ps2c_prev_q <= ps2c_s2_q;
      ps2d_s1_q   <= bus.ps2_data;
      ps2d_s2_q   <= ps2d_s1_q;
    end
  end

  assign w_fall = ps2c_prev_q & ~ps2c_s2_q;

  // Deframing FSM
  state_t         state_q, state_d;
  logic [3:0]     bitcnt_q, bitcnt_d;
  logic [9:0]     shreg_q, shreg_d;
  logic [TW-1:0]  tocnt_q, tocnt_d;
  logic           frame_err_q, frame_err_d;
  logic           w_push_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= 4'd0;
      shreg_q     <= 10'd0;
      tocnt_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      tocnt_q     <= tocnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    tocnt_d     = tocnt_q;
    frame_err_d = 1'b0;
    w_push_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tocnt_d = '0;
        if (w_fall && !ps2d_s2_q) begin
          state_d  = S_RECV;
          bitcnt_d = 4'd0;
          shreg_d  = 10'd0;
        end
      end
      S_RECV: begin
        if (w_fall) begin
          // LSB-first: after ten shifts [7:0]=data, [8]=parity, [9]=stop.
          shreg_d = {ps2d_s2_q, shreg_q[9:1]};
          tocnt_d = '0;
          if (bitcnt_q == c_STOP_BIT) begin
            state_d = S_CHECK;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end else if (tocnt_q == c_TO_LAST) begin
          state_d     = S_IDLE;
          tocnt_d     = '0;
          frame_err_d = 1'b1;
        end else begin
          tocnt_d = tocnt_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if ((^shreg_q[8:0]) && shreg_q[9]) begin
          w_push_req = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Scancode FIFO
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic        w_empty, w_full, w_do_push, w_do_pop;

  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  assign w_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_do_pop  = bus.kbd_read_enable && !w_empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign w_do_push = w_push_req && (!w_full || w_do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (w_do_push) begin
      wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + c_PTR_ONE;
    end
    if (w_push_req && w_full && !w_do_pop) begin
      ovf_d = 1'b1;
    end else if (w_do_pop && !w_do_push && ((rd_ptr_q + c_PTR_ONE) == wr_ptr_q)) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shreg_q[7:0];
    end
  end

  assign bus.kbd_ready    = !w_empty;
  assign bus.kbd_data     = w_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.kbd_overflow = ovf_q;
  assign bus.frame_err    = frame_err_q;

endmodule

`default_nettype wire
